// File: rtl/kmc_useq_if.sv
// Maintenance-vector and execution-control bundle between the KMC11 maintenance
// register, the microsequencer and its CRAM / IR / line-unit consumers.
interface kmc_useq_if;
    logic [7:0] kmcMAINT;
    logic [9:0] kmcMADDR;
    logic       kmcBRANCH;
    logic [9:0] kmcBRADDR;
    logic [9:0] kmcPC;
    logic [9:0] kmcCRAMA;
    logic       kmcCRAMWE;
    logic       kmcIRSEL;
    logic       kmcEXEC;
    logic       kmcLUCLK;
    logic       kmcLULOOP;
    logic       kmcRUNNING;

    modport master (
        output kmcMAINT, kmcMADDR, kmcBRANCH, kmcBRADDR,
        input  kmcPC, kmcCRAMA, kmcCRAMWE, kmcIRSEL, kmcEXEC,
        input  kmcLUCLK, kmcLULOOP, kmcRUNNING
    );

    modport slave (
        input  kmcMAINT, kmcMADDR, kmcBRANCH, kmcBRADDR,
        output kmcPC, kmcCRAMA, kmcCRAMWE, kmcIRSEL, kmcEXEC,
        output kmcLUCLK, kmcLULOOP, kmcRUNNING
    );
endinterface

// File: rtl/kmc_useq.sv
// KMC11 microsequencer: turns the maintenance vector into run/step/clear
// sequencing, micro-PC maintenance, CRAM addressing and line-unit clocking.
module kmc_useq #(
    parameter int CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    kmc_useq_if.slave   bus
);

    localparam int            PW      = $clog2(CYCLES);
    localparam logic [PW-1:0] PH_ZERO = PW'(0);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(CYCLES - 1);

    localparam logic [1:0] S_HALT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    logic run_s, mclr_s, cramwr_s, lustep_s, luloop_s, cramout_s, cramin_s, step_s;
    logic active_s;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [9:0]    pc_q, pc_d;
    logic [9:0]    crama_q, crama_d;
    logic          we_q, we_d;
    logic          exec_q, exec_d;
    logic          irsel_q, luloop_q, lustep_q, running_q;
    logic          luclk_q, luclk_d;

    assign {run_s, mclr_s, cramwr_s, lustep_s, luloop_s, cramout_s, cramin_s, step_s} = bus.kmcMAINT;

    // Sequencer next state, phase, micro-PC and write strobe.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pc_d    = pc_q;
        we_d    = 1'b0;
        if (mclr_s) begin
            state_d = S_CLEAR;
            ph_d    = PH_ZERO;
            pc_d    = 10'd0;
        end else begin
            pc_d = exec_q ? (bus.kmcBRANCH ? bus.kmcBRADDR : pc_q + 10'd1) : pc_q;
            case (state_q)
                S_HALT: begin
                    ph_d = PH_ZERO;
                    if (run_s) begin
                        state_d = S_RUN;
                    end else if (step_s) begin
                        state_d = S_STEP;
                    end else begin
                        state_d = S_HALT;
                        we_d    = cramwr_s;
                    end
                end
                // RUN and STEP share the microcycle; only the wrap decides what follows.
                S_RUN, S_STEP: begin
                    if (ph_q == PH_LAST) begin
                        ph_d    = PH_ZERO;
                        state_d = run_s ? S_RUN : S_HALT;
                    end else begin
                        ph_d    = ph_q + PH_ONE;
                        state_d = state_q;
                    end
                end
                S_CLEAR: begin
                    state_d = S_HALT;
                    ph_d    = PH_ZERO;
                end
                default: begin
                    state_d = S_HALT;
                    ph_d    = PH_ZERO;
                end
            endcase
        end
    end

    // Output decode computed from next state so every output lands registered.
    always_comb begin
        active_s = (state_d == S_RUN) || (state_d == S_STEP);
        exec_d   = active_s && (ph_d == PH_LAST);
        crama_d  = ((state_d == S_HALT) && (cramout_s || we_d)) ? bus.kmcMADDR : pc_d;
        luclk_d  = lustep_s & ~lustep_q;
    end

    // State and output registers; async reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_HALT;
            ph_q      <= PH_ZERO;
            pc_q      <= 10'd0;
            crama_q   <= 10'd0;
            we_q      <= 1'b0;
            exec_q    <= 1'b0;
            irsel_q   <= 1'b0;
            luloop_q  <= 1'b0;
            lustep_q  <= 1'b0;
            luclk_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            pc_q      <= pc_d;
            crama_q   <= crama_d;
            we_q      <= we_d;
            exec_q    <= exec_d;
            irsel_q   <= cramin_s;
            luloop_q  <= luloop_s;
            lustep_q  <= lustep_s;
            luclk_q   <= luclk_d;
            running_q <= (state_d == S_RUN);
        end
    end

    assign bus.kmcPC      = pc_q;
    assign bus.kmcCRAMA   = crama_q;
    assign bus.kmcCRAMWE  = we_q;
    assign bus.kmcEXEC    = exec_q;
    assign bus.kmcIRSEL   = irsel_q;
    assign bus.kmcLUCLK   = luclk_q;
    assign bus.kmcLULOOP  = luloop_q;
    assign bus.kmcRUNNING = running_q;

endmodule

// File: tb/tb_kmc_useq.sv
// Table-driven scoreboard bench for kmc_useq with CYCLES=4.
module tb_kmc_useq;

    localparam logic [7:0] M_RUN   = 8'h80;
    localparam logic [7:0] M_MCLR  = 8'h40;
    localparam logic [7:0] M_WR    = 8'h20;
    localparam logic [7:0] M_LUS   = 8'h10;
    localparam logic [7:0] M_LUL   = 8'h08;
    localparam logic [7:0] M_COUT  = 8'h04;
    localparam logic [7:0] M_CIN   = 8'h02;
    localparam logic [7:0] M_STEP  = 8'h01;

    typedef struct {
        logic [7:0]  maint;
        logic [9:0]  maddr;
        logic        br;
        logic [9:0]  braddr;
        logic [25:0] exp;
    } vec_t;

    typedef struct {
        int          idx;
        logic [25:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    sb_t  sbq[$];
    logic [25:0] dut_out;

    kmc_useq_if bus ();

    kmc_useq #(.CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign dut_out = {bus.kmcPC, bus.kmcCRAMA, bus.kmcCRAMWE, bus.kmcEXEC,
                      bus.kmcLUCLK, bus.kmcLULOOP, bus.kmcIRSEL, bus.kmcRUNNING};

    // expected = {pc, crama, we, exec, luclk, luloop, irsel, running}
    function automatic vec_t mk(logic [7:0] m, logic [9:0] ma, logic br, logic [9:0] ba,
                                logic [9:0] pc, logic [9:0] ca, logic we, logic ex,
                                logic lc, logic ll, logic ir, logic rn);
        vec_t v;
        v.maint  = m;
        v.maddr  = ma;
        v.br     = br;
        v.braddr = ba;
        v.exp    = {pc, ca, we, ex, lc, ll, ir, rn};
        return v;
    endfunction

    task automatic chk(input string name, input logic [25:0] act, input logic [25:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got pc=%0h crama=%0h we/ex/lc/ll/ir/rn=%b required pc=%0h crama=%0h we/ex/lc/ll/ir/rn=%b",
                     name, act[25:16], act[15:6], act[5:0], req[25:16], req[15:6], req[5:0]);
        end
    endtask

    task automatic drive(input logic [7:0] m, input logic [9:0] ma, input logic br, input logic [9:0] ba);
        bus.kmcMAINT  = m;
        bus.kmcMADDR  = ma;
        bus.kmcBRANCH = br;
        bus.kmcBRADDR = ba;
    endtask

    initial begin
        sb_t s;
        drive(8'h00, 10'd0, 1'b0, 10'd0);

        // single step from reset
        tbl.push_back(mk(M_STEP, 10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,1,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        // step with branch to 1022 taken while SEL6 is selected
        tbl.push_back(mk(M_STEP, 10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,1,0,0,0,0));
        tbl.push_back(mk(M_CIN,  10'd0, 1'b1, 10'd1022, 10'd1022, 10'd1022, 0,0,0,0,1,0));
        // run with PC wrap 1022 -> 1023 -> 0 -> branch 0x155
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd1022, 10'd1022, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd1022, 10'd1022, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd1022, 10'd1022, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd1022, 10'd1022, 0,1,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd1023, 10'd1023, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd1023, 10'd1023, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd1023, 10'd1023, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd1023, 10'd1023, 0,1,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,1,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b1, 10'h155,  10'h155, 10'h155, 0,0,0,0,0,1));
        // RUN dropped at ph=1 with a stray STEP pulse
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'h155, 10'h155, 0,0,0,0,0,1));
        tbl.push_back(mk(M_STEP, 10'd0, 1'b0, 10'd0,    10'h155, 10'h155, 0,0,0,0,0,1));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'h155, 10'h155, 0,1,0,0,0,1));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'h156, 10'h156, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'h156, 10'h156, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'h156, 10'h156, 0,0,0,0,0,0));
        // CRAM write and CRAMOUT in HALT
        tbl.push_back(mk(M_WR,   10'h2A5, 1'b0, 10'd0,  10'h156, 10'h2A5, 1,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'h2A5, 1'b0, 10'd0,  10'h156, 10'h156, 0,0,0,0,0,0));
        tbl.push_back(mk(M_COUT, 10'h0F0, 1'b0, 10'd0,  10'h156, 10'h0F0, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'h0F0, 1'b0, 10'd0,  10'h156, 10'h156, 0,0,0,0,0,0));
        // CRAMWR ignored in RUN, then MCLR held 7 cycles from ph=2
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'h156, 10'h156, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN | M_WR, 10'h2A5, 1'b0, 10'd0, 10'h156, 10'h156, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'h156, 10'h156, 0,0,0,0,0,1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(M_RUN | M_MCLR, 10'd0, 1'b0, 10'd0, 10'd0, 10'd0, 0,0,0,0,0,0));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,0));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,0,0,0,0,1));
        tbl.push_back(mk(M_RUN,  10'd0, 1'b0, 10'd0,    10'd0, 10'd0, 0,1,0,0,0,1));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        // line unit: LUSTEP 0->1->1 gives one clock pulse
        tbl.push_back(mk(M_LUS | M_LUL | M_CIN, 10'd0, 1'b0, 10'd0, 10'd1, 10'd1, 0,0,1,1,1,0));
        tbl.push_back(mk(M_LUS,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        tbl.push_back(mk(M_LUS,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));
        tbl.push_back(mk(M_LUS,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,1,0,0,0));
        tbl.push_back(mk(8'h00,  10'd0, 1'b0, 10'd0,    10'd1, 10'd1, 0,0,0,0,0,0));

        repeat (3) @(negedge clk);
        chk("reset_state", dut_out, 26'd0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                s = sbq.pop_front();
                chk($sformatf("row%0d", s.idx), dut_out, s.exp);
            end
            drive(tbl[i].maint, tbl[i].maddr, tbl[i].br, tbl[i].braddr);
            s.idx = i;
            s.exp = tbl[i].exp;
            sbq.push_back(s);
        end
        @(negedge clk);
        if (sbq.size() > 0) begin
            s = sbq.pop_front();
            chk($sformatf("row%0d", s.idx), dut_out, s.exp);
        end
        drive(8'h00, 10'd0, 1'b0, 10'd0);

        // async reset in the middle of a STEP microcycle (PC is 1 here)
        @(negedge clk);
        drive(M_STEP | M_CIN, 10'd0, 1'b0, 10'd0);
        @(negedge clk);
        drive(8'h00, 10'd0, 1'b0, 10'd0);
        @(negedge clk);
        chk("pre_rst_step", dut_out, {10'd1, 10'd1, 6'b000000});
        rst = 1'b0;
        #1;
        chk("async_rst_step", dut_out, 26'd0);
        @(negedge clk);
        rst = 1'b1;

        // async reset in the middle of a CRAM write strobe
        @(negedge clk);
        drive(M_WR, 10'h3FF, 1'b0, 10'd0);
        @(posedge clk);
        #1;
        chk("wr_strobe", dut_out, {10'd0, 10'h3FF, 6'b100000});
        rst = 1'b0;
        #1;
        chk("async_rst_write", dut_out, 26'd0);
        drive(8'h00, 10'd0, 1'b0, 10'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", dut_out, 26'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
